ika9958_vram_slot_sched: RTL and testbench
==========================================

// Module: ika9958_vram_slot_sched
// PURPOSE
//  Per-line VRAM access slot scheduler, driven by the screen-timing horizontal counter.
//  Divides every line into 2-cycle access slots and assigns each slot to one owner:
//  display fetch, DRAM refresh, CPU port or command engine.
//  Sits between the timing block and the VRAM controller. Its registered owner code
//  selects the VRAM address/data mux.
// PARAMETERS
//  HLAST       340  last hcntr value of a line; the slot starting here is always IDLE
//  REF_H       230  hcntr value at which one refresh request is queued per line
//  REF_MAX     3    refresh pending counter saturation value (2-bit counter)
//  STARVE_LIM  3    consecutive contested slots CPU may win before CMD is forced
// PORTS
//  i_phiA        in   1  master clock
//  i_RST_n       in   1  synchronous active-low reset
//  i_phiL_NCEN   in   1  clock enable; all state advances only when high
//  i_hcntr       in   9  horizontal counter, 0..HLAST, +1 per enabled cycle
//  i_disp_en     in   1  active display line; display fetch slots are reserved
//  i_cpu_req     in   1  CPU port access request; level, held until ack
//  i_cmd_req     in   1  command engine access request; level, held until ack
//  o_cpu_ack     out  1  1-enabled-cycle pulse at start of a CPU slot
//  o_cmd_ack     out  1  1-enabled-cycle pulse at start of a CMD slot
//  o_owner       out  3  0=IDLE 1=DISP 2=REF 3=CPU 4=CMD; held for the whole slot
//  o_slot_start  out  1  high in first cycle of every slot
//  o_ref_pend    out  2  refresh pending count
// BEHAVIOUR
//  Reset (i_RST_n low at posedge, regardless of NCEN):
//   - all outputs 0, owner IDLE
//   - starve counter 0, pending 0, FSM in IDLE
//  Slot boundary: enabled cycle with i_hcntr[0]==0.
//   - Decision is made from inputs at the boundary; outputs register on that edge (latency 1).
//   - Slot = 2 enabled cycles.
//  FSM states: IDLE, SLOT1 (first cycle), SLOT2 (second cycle).
//   - At a boundary, go to SLOT1 from any state.
//   - SLOT1 -> SLOT2 on the next enabled cycle. SLOT2 -> IDLE if no boundary follows.
//   - A boundary arriving in SLOT1 (hcntr wrap HLAST->0) truncates the slot.
//  Owner priority at a boundary:
//   1. hcntr==HLAST -> IDLE (dead slot, no ack).
//   2. i_disp_en && i_hcntr[2:1]==0 -> DISP.
//   3. ref_pend!=0 -> REF; pending decrements.
//   4. CPU and CMD both requesting ("contested"):
//      - CPU wins unless starve==STARVE_LIM, then CMD wins and starve=0.
//      - On a CPU win, starve increments.
//   5. Only one requester -> that one; starve=0.
//   6. Otherwise IDLE.
//  Ack timing:
//   - ack pulses in SLOT1 only.
//   - A requester that sees ack must deassert the next enabled cycle.
//   - A still-high req in SLOT2 is a new request.
//   - req is not re-evaluated until the next boundary.
//  Refresh counter:
//   - +1 on the enabled cycle with hcntr==REF_H; saturates at REF_MAX.
//   - Increment and REF-grant decrement in the same cycle -> unchanged.
//  o_owner/acks are frozen while i_phiL_NCEN low; pulses last one enabled cycle.
//  Reset mid-slot: slot aborted, no ack; requests re-arbitrate from the next boundary.
//  No combinational path from inputs to outputs.
// TESTING
//  1. Reset, hcntr free-running, disp_en=0, no req.
//     -> owner IDLE everywhere except REF for one slot starting at hcntr 232; pend 1->0.
//  2. disp_en=1, cpu_req held.
//     -> DISP at hcntr 0,8,16...; CPU at hcntr 2; cpu_ack one cycle; no ack in SLOT2.
//  3. cpu_req and cmd_req both held continuously, disp_en=0, STARVE_LIM=3.
//     -> grant sequence CPU,CPU,CPU,CMD repeating.
//  4. cpu_req held, REF_H slot taken by DISP at line end.
//     -> refresh deferred; served at next free slot.
//  5. Refresh pending saturation:
//     - block refresh 5 lines -> o_ref_pend stops at 3.
//     - pend=1 when increment and REF-grant coincide -> pend stays 1.
//  6. Wrap and reset edge cases:
//     - cpu_req at hcntr=340 -> IDLE, ack at hcntr 0 slot.
//     - i_RST_n low in SLOT1 -> all outputs 0 next edge.

Source files
------------

// File: rtl/ika9958_vram_slot_sched.sv
// ---------------------------------------------------------------------------
// ika9958_vram_slot_sched
//
// Per-line VRAM access slot scheduler. Every line is cut into 2-cycle access
// slots, one slot starting on each enabled cycle whose horizontal count is
// even. At the start of a slot one owner is chosen: display fetch, DRAM
// refresh, CPU port or command engine. The registered owner code drives the
// VRAM address/data mux in the controller downstream.
//
// Ports
//   i_phiA        master clock
//   i_RST_n       synchronous active-low reset (acts even with enable low)
//   i_phiL_NCEN   clock enable; all state advances only when high
//   i_hcntr       horizontal counter, 0..HLAST, +1 per enabled cycle
//   i_disp_en     active display line; every fourth slot is a display fetch
//   i_cpu_req     CPU port access request (level, held until ack)
//   i_cmd_req     command engine access request (level, held until ack)
//   o_cpu_ack     one enabled-cycle pulse in the first cycle of a CPU slot
//   o_cmd_ack     one enabled-cycle pulse in the first cycle of a CMD slot
//   o_owner       0=IDLE 1=DISP 2=REF 3=CPU 4=CMD, held for the whole slot
//   o_slot_start  high in the first cycle of every slot
//   o_ref_pend    refresh requests waiting for a slot
// ---------------------------------------------------------------------------
module ika9958_vram_slot_sched #(
   parameter int HLAST      = 340,
   parameter int REF_H      = 230,
   parameter int REF_MAX    = 3,
   parameter int STARVE_LIM = 3
) (
   input  logic       i_phiA,
   input  logic       i_RST_n,
   input  logic       i_phiL_NCEN,
   input  logic [8:0] i_hcntr,
   input  logic       i_disp_en,
   input  logic       i_cpu_req,
   input  logic       i_cmd_req,
   output logic       o_cpu_ack,
   output logic       o_cmd_ack,
   output logic [2:0] o_owner,
   output logic       o_slot_start,
   output logic [1:0] o_ref_pend
);

   localparam int SW = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);

   localparam logic [2:0] OWN_IDLE = 3'd0;
   localparam logic [2:0] OWN_DISP = 3'd1;
   localparam logic [2:0] OWN_REF  = 3'd2;
   localparam logic [2:0] OWN_CPU  = 3'd3;
   localparam logic [2:0] OWN_CMD  = 3'd4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SLOT1 = 2'd1,
      ST_SLOT2 = 2'd2
   } state_t;

   state_t        state;
   logic [SW-1:0] starve;

   logic          boundary;
   logic          ref_inc;
   logic          ref_dec;
   logic [2:0]    nxt_owner;
   logic [SW-1:0] nxt_starve;

   // Request/ack handshake: a requester raises req and holds it. The
   // scheduler samples req only at a slot boundary; a granted slot is flagged
   // by a one enabled-cycle ack in its first cycle, and the requester drops
   // req on the following enabled cycle. A req still high during the second
   // slot cycle is treated as a fresh request at the next boundary.

   assign boundary = i_phiL_NCEN && !i_hcntr[0];
   assign ref_inc  = (i_hcntr == 9'(REF_H));
   assign ref_dec  = boundary && (nxt_owner == OWN_REF);

   // Owner selection for the slot that starts on this cycle. When CPU and
   // command engine contend, CPU wins until it has won STARVE_LIM contested
   // slots in a row; the next contested slot is forced to the command engine.
   always_comb begin
      nxt_owner  = OWN_IDLE;
      nxt_starve = starve;
      if (i_hcntr == 9'(HLAST)) begin
         nxt_owner = OWN_IDLE;
      end else if (i_disp_en && (i_hcntr[2:1] == 2'b00)) begin
         nxt_owner = OWN_DISP;
      end else if (o_ref_pend != 2'd0) begin
         nxt_owner = OWN_REF;
      end else if (i_cpu_req && i_cmd_req) begin
         if (starve == SW'(STARVE_LIM)) begin
            nxt_owner  = OWN_CMD;
            nxt_starve = '0;
         end else begin
            nxt_owner  = OWN_CPU;
            nxt_starve = starve + SW'(1);
         end
      end else if (i_cpu_req) begin
         nxt_owner  = OWN_CPU;
         nxt_starve = '0;
      end else if (i_cmd_req) begin
         nxt_owner  = OWN_CMD;
         nxt_starve = '0;
      end
   end

   always_ff @(posedge i_phiA) begin
      if (!i_RST_n) begin
         state        <= ST_IDLE;
         starve       <= '0;
         o_ref_pend   <= 2'd0;
         o_owner      <= OWN_IDLE;
         o_slot_start <= 1'b0;
         o_cpu_ack    <= 1'b0;
         o_cmd_ack    <= 1'b0;
      end else if (i_phiL_NCEN) begin
         // A queued refresh and a refresh grant on the same cycle cancel.
         if (ref_inc && !ref_dec) begin
            if (o_ref_pend != 2'(REF_MAX)) begin
               o_ref_pend <= o_ref_pend + 2'd1;
            end
         end else if (ref_dec && !ref_inc) begin
            o_ref_pend <= o_ref_pend - 2'd1;
         end

         if (boundary) begin
            // Also taken from SLOT1: the HLAST->0 wrap truncates that slot.
            state        <= ST_SLOT1;
            starve       <= nxt_starve;
            o_owner      <= nxt_owner;
            o_slot_start <= 1'b1;
            o_cpu_ack    <= (nxt_owner == OWN_CPU);
            o_cmd_ack    <= (nxt_owner == OWN_CMD);
         end else begin
            o_slot_start <= 1'b0;
            o_cpu_ack    <= 1'b0;
            o_cmd_ack    <= 1'b0;
            case (state)
               ST_SLOT1: state <= ST_SLOT2;
               default: begin
                  state   <= ST_IDLE;
                  o_owner <= OWN_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ika9958_vram_slot_sched.sv
// ---------------------------------------------------------------------------
// Bench for ika9958_vram_slot_sched. A second instance with REF_H on a
// display-fetch position lets refresh be held off long enough to saturate
// the pending counter.
// ---------------------------------------------------------------------------
module tb_ika9958_vram_slot_sched;

   localparam int HLAST      = 340;
   localparam int REF_H      = 230;
   localparam int REF_MAX    = 3;
   localparam int STARVE_LIM = 3;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n   = 1'b0;
   logic       en      = 1'b0;
   logic [8:0] hcntr   = 9'd0;
   logic       disp_en = 1'b0;
   logic       cpu_req = 1'b0;
   logic       cmd_req = 1'b0;

   logic       cpu_ack, cmd_ack, slot_start;
   logic [2:0] owner;
   logic [1:0] ref_pend;

   logic       b_cpu_ack, b_cmd_ack, b_slot_start;
   logic [2:0] b_owner;
   logic [1:0] b_ref_pend;

   ika9958_vram_slot_sched dut (
      .i_phiA       (clk),
      .i_RST_n      (rst_n),
      .i_phiL_NCEN  (en),
      .i_hcntr      (hcntr),
      .i_disp_en    (disp_en),
      .i_cpu_req    (cpu_req),
      .i_cmd_req    (cmd_req),
      .o_cpu_ack    (cpu_ack),
      .o_cmd_ack    (cmd_ack),
      .o_owner      (owner),
      .o_slot_start (slot_start),
      .o_ref_pend   (ref_pend)
   );

   ika9958_vram_slot_sched #(.REF_H(232)) dut_b (
      .i_phiA       (clk),
      .i_RST_n      (rst_n),
      .i_phiL_NCEN  (en),
      .i_hcntr      (hcntr),
      .i_disp_en    (disp_en),
      .i_cpu_req    (cpu_req),
      .i_cmd_req    (cmd_req),
      .o_cpu_ack    (b_cpu_ack),
      .o_cmd_ack    (b_cmd_ack),
      .o_owner      (b_owner),
      .o_slot_start (b_slot_start),
      .o_ref_pend   (b_ref_pend)
   );

   // ---------------- scoreboard counters ----------------
   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   // Tracks which owner the latest slot got and how many enabled cycles ago
   // it started; the owner is visible for two enabled cycles after a slot
   // start, then the bus reads idle.
   int         m_pend       = 0;
   int         m_starve     = 0;
   int         m_since      = 2;
   int         m_slot_owner = 0;
   logic [2:0] exp_owner    = 3'd0;
   logic       exp_start    = 1'b0;
   logic       exp_cpu_ack  = 1'b0;
   logic       exp_cmd_ack  = 1'b0;
   logic [1:0] exp_pend     = 2'd0;
   bit         chk_on       = 1'b0;

   function automatic int pick_owner(int h, bit disp, bit cpu, bit cmd, int pend, int starve);
      if (h == HLAST) return 0;
      if (disp && (h % 8) == 0) return 1;
      if (pend > 0) return 2;
      if (cpu && cmd) return (starve == STARVE_LIM) ? 4 : 3;
      if (cpu) return 3;
      if (cmd) return 4;
      return 0;
   endfunction

   task automatic model_step(input int h);
      int own;
      if (!rst_n) begin
         m_pend = 0; m_starve = 0; m_since = 2; m_slot_owner = 0;
         exp_owner = 3'd0; exp_start = 1'b0; exp_cpu_ack = 1'b0;
         exp_cmd_ack = 1'b0; exp_pend = 2'd0;
         return;
      end
      if (!en) return;
      if ((h % 2) == 0) begin
         own = pick_owner(h, disp_en, cpu_req, cmd_req, m_pend, m_starve);
         if (own == 2) m_pend = m_pend - 1;
         if (own == 3 || own == 4)
            m_starve = (cpu_req && cmd_req && own == 3) ? m_starve + 1 : 0;
         m_slot_owner = own;
         m_since      = 0;
         exp_owner    = 3'(own);
         exp_start    = 1'b1;
         exp_cpu_ack  = (own == 3);
         exp_cmd_ack  = (own == 4);
      end else begin
         m_since     = (m_since < 2) ? m_since + 1 : 2;
         exp_start   = 1'b0;
         exp_cpu_ack = 1'b0;
         exp_cmd_ack = 1'b0;
         exp_owner   = (m_since <= 1) ? 3'(m_slot_owner) : 3'd0;
      end
      if (h == REF_H) m_pend = m_pend + 1;
      if (m_pend > REF_MAX) m_pend = REF_MAX;
      exp_pend = 2'(m_pend);
   endtask

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      if (chk_on) begin
         check("owner",      8'(owner),      8'(exp_owner));
         check("slot_start", 8'(slot_start), 8'(exp_start));
         check("cpu_ack",    8'(cpu_ack),    8'(exp_cpu_ack));
         check("cmd_ack",    8'(cmd_ack),    8'(exp_cmd_ack));
         check("ref_pend",   8'(ref_pend),   8'(exp_pend));
      end
   end

   // ---------------- driver tasks ----------------
   // One clock: present enable and hcntr, let the edge happen, then advance
   // the model with the inputs that were sampled on that edge.
   task automatic cyc(input bit e, input int h);
      en    = e;
      hcntr = 9'(h);
      @(posedge clk);
      #1;
      model_step(h);
      chk_on = 1'b1;
   endtask

   task automatic run(input int h0, input int h1);
      for (int h = h0; h <= h1; h++) cyc(1'b1, h);
   endtask

   task automatic do_reset();
      disp_en = 1'b0; cpu_req = 1'b0; cmd_req = 1'b0;
      rst_n = 1'b0;
      cyc(1'b1, 0);
      cyc(1'b0, 0);
      rst_n = 1'b1;
   endtask

   // ---------------- directed tests ----------------
   initial begin
      // 1: idle line, single refresh slot at 232
      do_reset();
      check("rst_owner", 8'(owner), 8'd0);
      check("rst_pend",  8'(ref_pend), 8'd0);
      check("rst_start", 8'(slot_start), 8'd0);
      for (int h = 0; h <= HLAST; h++) begin
         cyc(1'b1, h);
         if (h == 230) check("t1_pend_230", 8'(ref_pend), 8'd1);
         if (h == 232) begin
            check("t1_owner_232", 8'(owner), 8'd2);
            check("t1_pend_232",  8'(ref_pend), 8'd0);
         end
         if (h == 233) check("t1_owner_233", 8'(owner), 8'd2);
         if (h == 234) check("t1_owner_234", 8'(owner), 8'd0);
      end
      run(0, 3);

      // 2: display line with CPU held
      do_reset();
      disp_en = 1'b1; cpu_req = 1'b1;
      for (int h = 0; h <= 10; h++) begin
         cyc(1'b1, h);
         if (h == 0) check("t2_owner_0", 8'(owner), 8'd1);
         if (h == 2) begin
            check("t2_owner_2", 8'(owner), 8'd3);
            check("t2_ack_2",   8'(cpu_ack), 8'd1);
         end
         if (h == 3) begin
            check("t2_owner_3", 8'(owner), 8'd3);
            check("t2_ack_3",   8'(cpu_ack), 8'd0);
         end
         if (h == 8) check("t2_owner_8", 8'(owner), 8'd1);
      end
      // enable low: owner and ack frozen
      cyc(1'b0, 11);
      check("t2_frz_ack",   8'(cpu_ack), 8'd1);
      check("t2_frz_owner", 8'(owner), 8'd3);
      cyc(1'b1, 11);
      check("t2_rel_ack",   8'(cpu_ack), 8'd0);
      run(12, 17);

      // 3: contested CPU/CMD -> CPU,CPU,CPU,CMD
      do_reset();
      cpu_req = 1'b1; cmd_req = 1'b1;
      for (int h = 0; h <= 23; h++) begin
         cyc(1'b1, h);
         if ((h % 2) == 0)
            check("t3_grant", 8'(owner), (((h / 2) % 4) == 3) ? 8'd4 : 8'd3);
      end

      // 4: refresh deferred past a display slot
      do_reset();
      disp_en = 1'b1; cpu_req = 1'b1;
      for (int h = 0; h <= 240; h++) begin
         cyc(1'b1, h);
         if (h == 230) begin
            check("t4_owner_230", 8'(owner), 8'd3);
            check("t4_pend_230",  8'(ref_pend), 8'd1);
         end
         if (h == 232) check("t4_owner_232", 8'(owner), 8'd1);
         if (h == 234) begin
            check("t4_owner_234", 8'(owner), 8'd2);
            check("t4_pend_234",  8'(ref_pend), 8'd0);
         end
         if (h == 236) check("t4_owner_236", 8'(owner), 8'd3);
      end

      // 5a: saturation on the instance whose refresh point is a display slot
      do_reset();
      disp_en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cyc(1'b1, 232);
         check("t5_b_owner", 8'(b_owner), 8'd1);
         check("t5_b_pend",  8'(b_ref_pend), (i < 2) ? 8'(i + 1) : 8'd3);
         cyc(1'b1, 233);
      end
      disp_en = 1'b0;
      cyc(1'b1, 234);
      check("t5_b_ref",      8'(b_owner), 8'd2);
      check("t5_b_pend_dec", 8'(b_ref_pend), 8'd2);
      cyc(1'b1, 235);

      // 5b: increment and grant on the same cycle
      do_reset();
      cyc(1'b1, 230);
      check("t5_pend_1", 8'(ref_pend), 8'd1);
      cyc(1'b1, 231);
      cyc(1'b1, 230);
      check("t5_coinc_owner", 8'(owner), 8'd2);
      check("t5_coinc_pend",  8'(ref_pend), 8'd1);
      cyc(1'b1, 231);

      // 6: request at HLAST and reset inside a slot
      do_reset();
      run(336, 339);
      cpu_req = 1'b1;
      cyc(1'b1, 340);
      check("t6_owner_340", 8'(owner), 8'd0);
      check("t6_ack_340",   8'(cpu_ack), 8'd0);
      cyc(1'b1, 0);
      check("t6_owner_0", 8'(owner), 8'd3);
      check("t6_ack_0",   8'(cpu_ack), 8'd1);
      cpu_req = 1'b0;
      cyc(1'b1, 1);
      check("t6_ack_1", 8'(cpu_ack), 8'd0);
      cpu_req = 1'b1;
      cyc(1'b1, 2);
      check("t6_ack_2", 8'(cpu_ack), 8'd1);
      rst_n = 1'b0;
      cyc(1'b1, 3);
      check("t6_rst_owner", 8'(owner), 8'd0);
      check("t6_rst_ack",   8'(cpu_ack), 8'd0);
      check("t6_rst_start", 8'(slot_start), 8'd0);
      rst_n = 1'b1;
      cyc(1'b1, 4);
      check("t6_rearb_ack", 8'(cpu_ack), 8'd1);
      cpu_req = 1'b0;
      run(5, 9);

      @(posedge clk);
      chk_on = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
